// File: rtl/widths_shift_arbiter.sv
// Round-robin shared 8-bit logical shifter: one requester is served at a time,
// the result returns with the requester's index over a backpressured channel.
module widths_shift_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int CNT_W   = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [8*NUM_REQ-1:0]   req_data,
    input  logic [3*NUM_REQ-1:0]   req_amt,
    input  logic [NUM_REQ-1:0]     req_dir,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [7:0]             rsp_data,
    output logic [ID_W-1:0]        rsp_id,
    output logic                   busy,
    output logic [CNT_W-1:0]       op_count
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t             state_reg;
    logic [ID_W-1:0]    rr_ptr_reg;
    logic [ID_W-1:0]    gid_reg;
    logic [7:0]         data_reg;
    logic [2:0]         amt_reg;
    logic               dir_reg;
    logic               rsp_valid_reg;
    logic [7:0]         rsp_data_reg;
    logic [ID_W-1:0]    rsp_id_reg;
    logic [CNT_W-1:0]   op_count_reg;

    logic [7:0]         lane_data [NUM_REQ];
    logic [2:0]         lane_amt  [NUM_REQ];

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_lane
            assign lane_data[gi] = req_data[8*gi +: 8];
            assign lane_amt[gi]  = req_amt[3*gi +: 3];
        end
    endgenerate

    // Search upward from rr_ptr with wrap; the first valid lane wins.
    logic               grant_found;
    logic [ID_W-1:0]    grant_idx;
    logic [7:0]         grant_data;
    logic [2:0]         grant_amt;
    logic               grant_dir;
    int                 cand;

    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        grant_data  = '0;
        grant_amt   = '0;
        grant_dir   = 1'b0;
        cand        = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = (int'(rr_ptr_reg) + k) % NUM_REQ;
            for (int j = 0; j < NUM_REQ; j++) begin
                if (!grant_found && cand == j && req_valid[j]) begin
                    grant_found = 1'b1;
                    grant_idx   = ID_W'(j);
                    grant_data  = lane_data[j];
                    grant_amt   = lane_amt[j];
                    grant_dir   = req_dir[j];
                end
            end
        end
    end

    logic grant_accept;
    assign grant_accept = rst_n && (state_reg == IDLE) && grant_found;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ready
            assign req_ready[gi] = grant_accept && (grant_idx == ID_W'(gi));
        end
    endgenerate

    logic [7:0] shift_result;
    assign shift_result = dir_reg ? (data_reg >> amt_reg) : (data_reg << amt_reg);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            rr_ptr_reg    <= '0;
            gid_reg       <= '0;
            data_reg      <= '0;
            amt_reg       <= '0;
            dir_reg       <= 1'b0;
            rsp_valid_reg <= 1'b0;
            rsp_data_reg  <= '0;
            rsp_id_reg    <= '0;
            op_count_reg  <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (grant_found) begin
                        gid_reg   <= grant_idx;
                        data_reg  <= grant_data;
                        amt_reg   <= grant_amt;
                        dir_reg   <= grant_dir;
                        state_reg <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_data_reg  <= shift_result;
                    rsp_id_reg    <= gid_reg;
                    rsp_valid_reg <= 1'b1;
                    state_reg     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_reg <= 1'b0;
                        // Fairness pointer moves only once the result is consumed.
                        rr_ptr_reg    <= (gid_reg == ID_W'(NUM_REQ - 1)) ? '0 : gid_reg + ID_W'(1);
                        op_count_reg  <= op_count_reg + CNT_W'(1);
                        state_reg     <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign rsp_valid = rsp_valid_reg;
    assign rsp_data  = rsp_data_reg;
    assign rsp_id    = rsp_id_reg;
    assign op_count  = op_count_reg;
    assign busy      = (state_reg != IDLE);

endmodule

// File: tb/tb_widths_shift_arbiter.sv
// Randomized and directed stimulus for widths_shift_arbiter, checked every cycle
// against a transaction-level model of the shared shifter.
module tb_widths_shift_arbiter;

    localparam int N  = 4;
    localparam int IW = 2;
    localparam int CW = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [N-1:0]      req_valid;
    logic [8*N-1:0]    req_data;
    logic [3*N-1:0]    req_amt;
    logic [N-1:0]      req_dir;
    logic [N-1:0]      req_ready;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [7:0]        rsp_data;
    logic [IW-1:0]     rsp_id;
    logic              busy;
    logic [CW-1:0]     op_count;

    widths_shift_arbiter #(.NUM_REQ(N), .ID_W(IW), .CNT_W(CW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_amt   (req_amt),
        .req_dir   (req_dir),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id),
        .busy      (busy),
        .op_count  (op_count)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Model: one operation occupies the shifter from acceptance until its
    // result is consumed; the result is visible two cycles after acceptance.
    bit        m_busy;
    int        m_age;
    int        m_op_data, m_op_amt, m_op_id;
    bit        m_op_dir;
    bit        m_rsp_valid;
    int        m_rsp_data, m_rsp_id;
    int        m_count;
    int        m_rr;

    int        cyc = 0;
    int        last_grant = -1;
    logic [N-1:0] seen_ready;
    int        acc_cyc[$];
    int        acc_id[$];

    function automatic logic [7:0] shift_ref(input int d, input int a, input bit r);
        if (r) return 8'(d / (1 << a));
        return 8'((d * (1 << a)) % 256);
    endfunction

    function automatic int model_grant(input logic [N-1:0] v);
        for (int k = 0; k < N; k++) begin
            if (v[(m_rr + k) % N]) return (m_rr + k) % N;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_busy = 0; m_age = 0; m_rsp_valid = 0; m_rsp_data = 0; m_rsp_id = 0;
        m_count = 0; m_rr = 0; m_op_data = 0; m_op_amt = 0; m_op_id = 0; m_op_dir = 0;
    endtask

    // Called at the falling edge with inputs already driven; ends at the next falling edge.
    task automatic cycle();
        int g;
        #1;
        check_val("rsp_valid", rsp_valid, m_rsp_valid);
        check_val("rsp_data", rsp_data, m_rsp_data);
        check_val("rsp_id", rsp_id, m_rsp_id);
        check_val("busy", busy, m_busy);
        check_val("op_count", op_count, m_count);
        g = (rst_n && !m_busy) ? model_grant(req_valid) : -1;
        check_val("req_ready", req_ready, (g >= 0) ? (1 << g) : 0);
        seen_ready = req_ready;
        last_grant = g;
        if (g >= 0) begin
            acc_cyc.push_back(cyc);
            acc_id.push_back(g);
        end
        if (!rst_n) begin
            model_reset();
        end else if (!m_busy) begin
            if (g >= 0) begin
                m_busy = 1; m_age = 0; m_op_id = g;
                m_op_data = int'(req_data[8*g +: 8]);
                m_op_amt  = int'(req_amt[3*g +: 3]);
                m_op_dir  = req_dir[g];
            end
        end else if (m_age == 0) begin
            m_age = 1;
            m_rsp_valid = 1;
            m_rsp_data = int'(shift_ref(m_op_data, m_op_amt, m_op_dir));
            m_rsp_id = m_op_id;
        end else if (rsp_ready) begin
            $display("txn id=%0d data=%02h count=%0d", m_rsp_id, m_rsp_data[7:0], (m_count + 1) % (1 << CW));
            m_rsp_valid = 0;
            m_busy = 0;
            m_rr = (m_op_id + 1) % N;
            m_count = (m_count + 1) % (1 << CW);
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic set_req(input int i, input int d, input int a, input bit r);
        req_valid[i]        = 1'b1;
        req_data[8*i +: 8]  = 8'(d);
        req_amt[3*i +: 3]   = 3'(a);
        req_dir[i]          = r;
    endtask

    task automatic run_op(input int i, input int d, input int a, input bit r, input int exp);
        set_req(i, d, a, r);
        rsp_ready = 1'b1;
        cycle();
        check_val("op_ready", seen_ready, 1 << i);
        req_valid[i] = 1'b0;
        cycle();
        check_val("op_valid", rsp_valid, 1);
        check_val("op_data", rsp_data, exp);
        check_val("op_id", rsp_id, i);
        cycle();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
    endtask

    initial begin
        int cnt_before, d, a;
        rst_n = 1'b0; req_valid = '0; req_data = '0; req_amt = '0; req_dir = '0; rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        model_reset();
        do_reset();

        // Single left shift from requester 2
        run_op(2, 8'hB5, 3, 1'b0, 8'hA8);
        check_val("t1_count", op_count, 1);

        // Shift boundaries
        run_op(0, 8'h80, 7, 1'b1, 8'h01);
        run_op(1, 8'h5A, 0, 1'b0, 8'h5A);
        run_op(3, 8'hFF, 7, 1'b0, 8'h80);

        // All requesters valid continuously
        do_reset();
        for (int i = 0; i < N; i++) set_req(i, $urandom_range(0, 255), $urandom_range(0, 7), 1'($urandom_range(0, 1)));
        rsp_ready = 1'b1;
        acc_cyc.delete(); acc_id.delete();
        repeat (15) cycle();
        check_val("t3_accepts", acc_id.size(), 5);
        for (int k = 0; k < 5 && k < acc_id.size(); k++) check_val("t3_order", acc_id[k], k % N);
        for (int k = 1; k < 5 && k < acc_cyc.size(); k++) check_val("t3_gap", acc_cyc[k] - acc_cyc[k-1], 3);
        req_valid = '0;
        repeat (3) cycle();

        // Backpressure held in RESP
        set_req(1, 8'h3C, 2, 1'b1);
        rsp_ready = 1'b0;
        cycle();
        req_valid = 4'b1111;
        cycle();
        repeat (5) begin
            cycle();
            check_val("t4_ready", seen_ready, 0);
            check_val("t4_valid", rsp_valid, 1);
            check_val("t4_data", rsp_data, 8'h0F);
            check_val("t4_id", rsp_id, 1);
        end
        cnt_before = m_count;
        req_valid = '0;
        rsp_ready = 1'b1;
        cycle();
        check_val("t4_count", op_count, (cnt_before + 1) % (1 << CW));
        check_val("t4_idle", busy, 0);

        // Reset in EXEC
        set_req(0, 8'hF0, 1, 1'b0);
        cycle();
        req_valid = '0;
        set_req(1, 8'h11, 1, 1'b0);
        set_req(3, 8'h22, 1, 1'b1);
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        check_val("t5_valid", rsp_valid, 0);
        check_val("t5_busy", busy, 0);
        check_val("t5_count", op_count, 0);
        cycle();
        check_val("t5_grant", seen_ready, 4'b0010);
        req_valid[1] = 1'b0;
        repeat (6) cycle();
        req_valid = '0;
        repeat (3) cycle();

        // Randomized traffic with withdrawals, backpressure and occasional reset
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < N; i++) begin
                if (last_grant == i) begin
                    req_valid[i] = 1'b0;
                end else if (req_valid[i]) begin
                    if ($urandom_range(0, 19) == 0) req_valid[i] = 1'b0;
                end else if ($urandom_range(0, 2) == 0) begin
                    set_req(i, $urandom_range(0, 255), $urandom_range(0, 7), 1'($urandom_range(0, 1)));
                end
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
            rst_n = ($urandom_range(0, 299) != 0);
            cycle();
        end
        rst_n = 1'b1;
        req_valid = '0;

        // Counter wrap: 17 completions on a 4-bit counter
        do_reset();
        for (int k = 0; k < 17; k++) begin
            d = $urandom_range(0, 255);
            a = $urandom_range(0, 7);
            run_op(k % N, d, a, 1'(k % 2), int'(shift_ref(d, a, 1'(k % 2))));
        end
        check_val("t6_wrap", op_count, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
